auction_round_ctrl: RTL and testbench

Sequencer for one sealed-bid auction round over the shared argmax datapath. It opens a collection window, latches up to NREQ bids through a ready/valid handshake, and evaluates the masked maximum. It then issues a single grant and holds it until the winner releases it. It sits between the requester ports and the downstream resource whose ownership is being auctioned.

---
 rtl/auction_pkg.sv | 16 +
 rtl/bid_masked_argmax.sv | 32 +++
 rtl/auction_round_ctrl.sv | 132 +++++++++++++
 tb/tb_auction_round_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auction_pkg.sv
// Shared types and default sizes for the sealed-bid auction round sequencer.
package auction_pkg;

  localparam int unsigned NREQ_DEFAULT = 10;
  localparam int unsigned BW_DEFAULT   = 16;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    GRANT
  } state_t;

  typedef logic [$clog2(NREQ_DEFAULT)-1:0] idx_t;

endpackage

// File: rtl/bid_masked_argmax.sv
// Combinational masked argmax: largest unsigned bid among masked requesters,
// lowest index wins ties.
module bid_masked_argmax
  import auction_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned BW   = BW_DEFAULT
) (
  input  logic [BW-1:0]           bids [NREQ],
  input  logic [NREQ-1:0]         mask,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic [BW-1:0]           max_val,
  output logic                    any_valid
);

  localparam int unsigned IW = $clog2(NREQ);

  // Strict '>' keeps the earliest index on equal values.
  always_comb begin
    idx       = '0;
    max_val   = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (mask[i] && (!any_valid || bids[i] > max_val)) begin
        idx       = IW'(i);
        max_val   = bids[i];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/auction_round_ctrl.sv
// One sealed-bid auction round: collect, evaluate masked argmax, hold grant.
// AUCTION_HOLD_TIMEOUT_EN adds a HOLD_MAX grant revocation; the release strobe is release_req since release is reserved.
module auction_round_ctrl
  import auction_pkg::*;
#(
  parameter int unsigned NREQ           = NREQ_DEFAULT,
  parameter int unsigned BW             = BW_DEFAULT,
  parameter int unsigned COLLECT_CYCLES = 8,
  parameter int unsigned HOLD_MAX       = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NREQ-1:0]         bid_valid,
  input  logic [BW-1:0]           bids [NREQ],
  output logic                    bid_ready,
  output logic                    busy,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic [BW-1:0]           grant_bid,
  input  logic                    release_req,
  output logic                    no_bids,
  output logic                    timeout
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(COLLECT_CYCLES) + 1;

  if (NREQ < 2 || NREQ > 16 || COLLECT_CYCLES < 1 || HOLD_MAX < 1) begin : g_cfg_error
    $error("auction_round_ctrl: unsupported parameter set");
  end

  state_t          state, state_next;
  logic [NREQ-1:0] mask, mask_next;
  logic [BW-1:0]   bid_q [NREQ];
  logic [CW-1:0]   win_cnt;
  logic            win_last;
  logic            all_in;
  logic [IW-1:0]   arg_idx;
  logic [BW-1:0]   arg_max;
  logic            arg_any;
  logic            hold_last;

  assign mask_next = mask | bid_valid;
  assign all_in    = &mask_next;
  assign win_last  = (win_cnt == CW'(COLLECT_CYCLES - 1));

  bid_masked_argmax #(
    .NREQ (NREQ),
    .BW   (BW)
  ) u_argmax (
    .bids      (bid_q),
    .mask      (mask),
    .idx       (arg_idx),
    .max_val   (arg_max),
    .any_valid (arg_any)
  );

`ifdef AUCTION_HOLD_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX) + 1;
  logic [HW-1:0] hold_cnt;
  logic          timeout_q;

  assign hold_last = (hold_cnt == HW'(HOLD_MAX - 1));

  // Counter idles at zero outside GRANT, so each grant starts a fresh hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == GRANT) && !release_req && hold_last;
      hold_cnt  <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_last = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (win_last || all_in) state_next = EVAL;
      EVAL:    state_next = arg_any ? GRANT : IDLE;
      GRANT:   if (release_req || hold_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask      <= '0;
      win_cnt   <= '0;
      grant_idx <= '0;
      grant_bid <= '0;
      no_bids   <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) bid_q[i] <= '0;
    end else begin
      no_bids <= (state == EVAL) && !arg_any;
      if (state == IDLE && start) begin
        mask    <= '0;
        win_cnt <= '0;
        for (int unsigned i = 0; i < NREQ; i++) bid_q[i] <= '0;
      end
      if (state == COLLECT) begin
        mask    <= mask_next;
        win_cnt <= win_cnt + 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (bid_valid[i]) bid_q[i] <= bids[i];
        end
      end
      if (state == EVAL && arg_any) begin
        grant_idx <= arg_idx;
        grant_bid <= arg_max;
      end
    end
  end

  assign bid_ready   = (state == COLLECT);
  assign busy        = (state != IDLE);
  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_auction_round_ctrl.sv
// Self-checking bench for auction_round_ctrl: directed plan scenarios plus
// randomized traffic, all compared against a cycle-level reference model.
module tb_auction_round_ctrl;

  localparam int NREQ = 10;
  localparam int BW   = 16;
  localparam int CC   = 8;
  localparam int HM   = 64;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_EVAL = 2, P_GRANT = 3;

  logic            clk = 1'b0;
  logic            rst_n, start, release_req;
  logic [NREQ-1:0] bid_valid;
  logic [BW-1:0]   bids [NREQ];
  logic            bid_ready, busy, grant_valid, no_bids, timeout;
  logic [3:0]      grant_idx;
  logic [BW-1:0]   grant_bid;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_phase, m_win, m_hold;
  bit          m_mask [NREQ];
  int unsigned m_bid  [NREQ];
  int unsigned m_gidx, m_gbid;
  bit          m_nob, m_to;

  auction_round_ctrl #(
    .NREQ           (NREQ),
    .BW             (BW),
    .COLLECT_CYCLES (CC),
    .HOLD_MAX       (HM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bid_valid   (bid_valid),
    .bids        (bids),
    .bid_ready   (bid_ready),
    .busy        (busy),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_bid   (grant_bid),
    .release_req (release_req),
    .no_bids     (no_bids),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    int          n;
    bit          any;
    int unsigned maxv;
    if (!rst_n) begin
      m_phase = P_IDLE;
      foreach (m_mask[i]) begin m_mask[i] = 0; m_bid[i] = 0; end
      m_gidx = 0; m_gbid = 0; m_nob = 0; m_to = 0; m_win = 0; m_hold = 0;
      return;
    end
    m_nob = 0;
    m_to  = 0;
    case (m_phase)
      P_IDLE: if (start) begin
        foreach (m_mask[i]) begin m_mask[i] = 0; m_bid[i] = 0; end
        m_win   = 0;
        m_phase = P_COLLECT;
      end
      P_COLLECT: begin
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (bid_valid[i]) begin m_bid[i] = bids[i]; m_mask[i] = 1; end
          if (m_mask[i]) n++;
        end
        m_win++;
        if (m_win == CC || n == NREQ) m_phase = P_EVAL;
      end
      P_EVAL: begin
        any  = 0;
        maxv = 0;
        for (int i = 0; i < NREQ; i++)
          if (m_mask[i]) begin any = 1; if (m_bid[i] > maxv) maxv = m_bid[i]; end
        if (!any) begin
          m_nob   = 1;
          m_phase = P_IDLE;
        end else begin
          for (int i = NREQ - 1; i >= 0; i--)
            if (m_mask[i] && m_bid[i] == maxv) m_gidx = i;
          m_gbid  = maxv;
          m_hold  = 0;
          m_phase = P_GRANT;
        end
      end
      default: begin
        if (release_req) m_phase = P_IDLE;
`ifdef AUCTION_HOLD_TIMEOUT_EN
        else begin
          m_hold++;
          if (m_hold == HM) begin m_to = 1; m_phase = P_IDLE; end
        end
`endif
      end
    endcase
  endfunction

  task automatic check_all();
    check_eq("bid_ready",   bid_ready,   m_phase == P_COLLECT);
    check_eq("busy",        busy,        m_phase != P_IDLE);
    check_eq("grant_valid", grant_valid, m_phase == P_GRANT);
    check_eq("grant_idx",   grant_idx,   m_gidx);
    check_eq("grant_bid",   grant_bid,   m_gbid);
    check_eq("no_bids",     no_bids,     m_nob);
    check_eq("timeout",     timeout,     m_to);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check_eq(tag, grant_valid, 1);
  endtask

  task automatic junk_bids();
    for (int i = 0; i < NREQ; i++) bids[i] = BW'($urandom);
  endtask

  initial begin
    int vals [NREQ] = '{5, 9, 3, 7, 2, 8, 1, 4, 6, 0};
    int hi;
    int rel_mod;

    rst_n = 1'b0; start = 1'b0; release_req = 1'b0; bid_valid = '0;
    for (int i = 0; i < NREQ; i++) bids[i] = '0;
    @(negedge clk);
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_bid", grant_bid, 0);
    rst_n = 1'b1;
    tick();

    // full window, all bids in first COLLECT cycle -> early close
    start = 1; tick(); start = 0;
    check_eq("full_ready", bid_ready, 1);
    for (int i = 0; i < NREQ; i++) bids[i] = BW'(vals[i]);
    bid_valid = '1;
    tick();
    bid_valid = '0; junk_bids();
    check_eq("full_eval_gv", grant_valid, 0);
    check_eq("full_eval_ready", bid_ready, 0);
    tick();
    check_eq("full_gv", grant_valid, 1);
    check_eq("full_idx", grant_idx, 1);
    check_eq("full_bid", grant_bid, 9);

    start = 1; tick(); start = 0;
    check_eq("start_in_grant_gv", grant_valid, 1);
    check_eq("start_in_grant_ready", bid_ready, 0);
    release_req = 1; tick(); release_req = 0;
    check_eq("release_drop", grant_valid, 0);
    check_eq("release_idle", busy, 0);

    // start at r+1, partial bids with a large unmasked bids[0]
    start = 1; tick(); start = 0;
    check_eq("restart_ready", bid_ready, 1);
    junk_bids();
    bids[0] = 16'hFFFF; bids[7] = 16'h00FF; bids[2] = 16'h00FE;
    bid_valid = '0; bid_valid[7] = 1; bid_valid[2] = 1;
    tick();
    bid_valid = '0; junk_bids();
    for (int k = 2; k <= 10; k++) begin
      check_eq("partial_gv", grant_valid, k == 10);
      check_eq("partial_ready", bid_ready, k <= 8);
      if (k < 10) tick();
    end
    check_eq("partial_idx", grant_idx, 7);
    check_eq("partial_bid", grant_bid, 16'h00FF);
    release_req = 1; tick();
    tick();
    release_req = 0;
    check_eq("release_in_idle", busy, 0);
    check_eq("release_in_idle_idx", grant_idx, 7);

    // tie goes to lowest index
    start = 1; tick(); start = 0;
    bids[4] = 16'h0100; bids[6] = 16'h0100;
    bid_valid = '0; bid_valid[4] = 1; bid_valid[6] = 1;
    tick();
    bid_valid = '0; junk_bids();
    wait_grant("tie_wait");
    check_eq("tie_idx", grant_idx, 4);
    release_req = 1; tick(); release_req = 0;

    // overwrite bids[4] later in the window
    start = 1; tick(); start = 0;
    bids[4] = 16'h0100; bids[6] = 16'h0100;
    bid_valid = '0; bid_valid[4] = 1; bid_valid[6] = 1;
    tick();
    bid_valid = '0; junk_bids();
    tick();
    bids[4] = 16'h0001; bid_valid[4] = 1;
    tick();
    bid_valid = '0; junk_bids();
    wait_grant("ovw_wait");
    check_eq("ovw_idx", grant_idx, 6);
    check_eq("ovw_bid", grant_bid, 16'h0100);

    // reset mid-GRANT
    rst_n = 0; tick(); rst_n = 1;
    check_eq("rst_grant_gv", grant_valid, 0);
    check_eq("rst_grant_idx", grant_idx, 0);
    tick();

    // empty round
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 11; k++) begin
      check_eq("empty_no_bids", no_bids, k == 10);
      check_eq("empty_busy", busy, k <= 9);
      check_eq("empty_gv", grant_valid, 0);
      tick();
    end

    // reset mid-COLLECT
    start = 1; tick(); start = 0;
    bid_valid = 10'h0F3; junk_bids(); tick(); bid_valid = '0; tick();
    rst_n = 0; tick(); rst_n = 1;
    check_eq("rst_coll_ready", bid_ready, 0);
    check_eq("rst_coll_busy", busy, 0);
    tick();

    // grant hold without release
    start = 1; tick(); start = 0;
    bids[3] = 16'h1234; bid_valid = '0; bid_valid[3] = 1;
    tick();
    bid_valid = '0; junk_bids();
    wait_grant("hold_wait");
    hi = 1;
`ifdef AUCTION_HOLD_TIMEOUT_EN
    for (int k = 0; k < 200; k++) begin
      tick();
      if (grant_valid !== 1'b1) break;
      hi++;
    end
    check_eq("hold_len", hi, HM);
    check_eq("hold_timeout_pulse", timeout, 1);
    tick();
    check_eq("hold_timeout_clear", timeout, 0);
`else
    for (int k = 0; k < 100; k++) tick();
    check_eq("hold_persist", grant_valid, 1);
    check_eq("hold_no_timeout", timeout, 0);
    release_req = 1; tick(); release_req = 0;
`endif

    // randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      rel_mod = (blk % 2 == 0) ? 3 : 90;
      for (int c = 0; c < 500; c++) begin
        rst_n       = ($urandom_range(0, 299) != 0);
        start       = ($urandom_range(0, 3) == 0);
        release_req = ($urandom_range(0, rel_mod - 1) == 0);
        for (int i = 0; i < NREQ; i++) begin
          bid_valid[i] = ($urandom_range(0, 5) == 0);
          bids[i] = ($urandom_range(0, 1) == 0) ? BW'($urandom_range(0, 7)) : BW'($urandom);
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
